// File: rtl/usb_rx_sequencer.sv
// USB full-speed receive sequencer: NRZI decode, SYNC detection, bit
// unstuffing, byte assembly and end-of-packet / error signalling.
// Line symbols come from package types (defined at the top of this file).
// Optional build macro: USB_RX_STUFF_ERR_EN. When it is defined, a decoded 1
// in a stuff-bit slot (seven 1s in a row) aborts the packet with rx_error.
// When it is undefined, that bit is dropped like any other stuff bit.

package types;
  // Differential line value packed as {dp, dm}.
  typedef logic [1:0] d_port_t;
  localparam d_port_t J   = 2'b10;
  localparam d_port_t K   = 2'b01;
  localparam d_port_t SE0 = 2'b00;
endpackage

module usb_rx_sequencer
  import types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  input  d_port_t    q,
  output logic       rx_active,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_error,
  output logic       rx_eop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    EOP  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  d_port_t    prev_reg, prev_next;
  logic [2:0] ones_reg, ones_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] data_reg, data_next;
  logic       active_reg, active_next;
  logic       valid_reg, valid_next;
  logic       error_reg, error_next;
  logic       eop_reg, eop_next;

  // NRZI: no transition on the line means a 1.
  logic       dbit;
  logic [7:0] shifted;
  assign dbit    = (q == prev_reg);
  // Bits arrive LSB first, so each new bit enters at the top and moves down.
  assign shifted = {dbit, shift_reg[7:1]};

  // State and output registers; reset wins over any strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      prev_reg    <= J;
      ones_reg    <= 3'd0;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'h00;
      data_reg    <= 8'h00;
      active_reg  <= 1'b0;
      valid_reg   <= 1'b0;
      error_reg   <= 1'b0;
      eop_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      prev_reg    <= prev_next;
      ones_reg    <= ones_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      active_reg  <= active_next;
      valid_reg   <= valid_next;
      error_reg   <= error_next;
      eop_reg     <= eop_next;
    end
  end

  // Next-state decode: everything holds except on strobe; pulses default low.
  always_comb begin
    state_next   = state_reg;
    prev_next    = prev_reg;
    ones_next    = ones_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    error_next   = 1'b0;
    eop_next     = 1'b0;

    if (strobe) begin
      prev_next = q;
      unique case (state_reg)
        IDLE: begin
          if (q == K) begin
            state_next = SYNC;
            ones_next  = 3'd0;
          end
        end

        SYNC: begin
          if (q == SE0) begin
            state_next = IDLE;
          end else if (dbit) begin
            // The closing KK of SYNC is a decoded 1 and starts the run of
            // ones that the transmitter's bit stuffing also counts.
            state_next   = DATA;
            ones_next    = 3'd1;
            bit_cnt_next = 3'd0;
            shift_next   = 8'h00;
          end else begin
            ones_next = 3'd0;
          end
        end

        DATA: begin
          if (q == SE0) begin
            // A partial byte at EOP is a misalignment; it is never delivered.
            state_next = EOP;
            if (bit_cnt_reg != 3'd0) begin
              error_next = 1'b1;
            end
          end else if (ones_reg == 3'd6) begin
            // Stuff-bit slot: never shifted or counted.
            ones_next = 3'd0;
`ifdef USB_RX_STUFF_ERR_EN
            if (dbit) begin
              error_next = 1'b1;
              state_next = IDLE;
            end
`endif
          end else begin
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            ones_next    = dbit ? (ones_reg + 3'd1) : 3'd0;
            if (bit_cnt_reg == 3'd7) begin
              data_next  = shifted;
              valid_next = 1'b1;
            end
          end
        end

        EOP: begin
          if (q == J) begin
            state_next = IDLE;
            eop_next   = 1'b1;
          end else if (q == K) begin
            state_next = IDLE;
            error_next = 1'b1;
          end
        end

        default: state_next = IDLE;
      endcase
    end

    // rx_active follows the registered state so it drops together with the
    // final eop/error pulse.
    active_next = (state_next == DATA) || (state_next == EOP);
  end

  assign rx_active = active_reg;
  assign rx_valid  = valid_reg;
  assign rx_data   = data_reg;
  assign rx_error  = error_reg;
  assign rx_eop    = eop_reg;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Testbench for usb_rx_sequencer: directed packets plus random packets. The
// bench encodes bytes into NRZI with bit stuffing and predicts the byte, error
// and eop events from the packet contents.
`timescale 1ns/1ps
module tb_usb_rx_sequencer;
  import types::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       strobe;
  d_port_t    q;
  logic       rx_active, rx_valid, rx_error, rx_eop;
  logic [7:0] rx_data;

  usb_rx_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .strobe   (strobe),
    .q        (q),
    .rx_active(rx_active),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_error (rx_error),
    .rx_eop   (rx_eop)
  );

  // 24 MHz clock
  always #21 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected and observed events: 'h100|byte = byte, 'h200 = error, 'h300 = eop
  int exp_q[$];
  int obs_q[$];
  logic [7:0] last_byte = 8'h00;

  d_port_t lvl;   // encoder line level
  int      run;   // encoder run of consecutive 1s

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Record every output pulse; valid and error must never coincide
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid)  obs_q.push_back(32'h100 | int'(rx_data));
      if (rx_error)  obs_q.push_back(32'h200);
      if (rx_eop)    obs_q.push_back(32'h300);
      if (rx_valid || rx_error) check("valid_err_excl", {31'd0, rx_valid & rx_error}, 32'd0);
    end
  end

  // One strobed symbol after a random gap with junk on q
  task automatic send_sym(input d_port_t s);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      q = d_port_t'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    strobe = 1'b1;
    q = s;
    @(posedge clk); #1;
    strobe = 1'b0;
    q = d_port_t'($urandom_range(0, 3));
  endtask

  task automatic send_lvl(input bit b);
    if (!b) lvl = (lvl == J) ? K : J;
    send_sym(lvl);
  endtask

  task automatic stuff_if_needed();
    if (run == 6) begin
      send_lvl(1'b0);
      run = 0;
    end
  endtask

  task automatic send_bit(input bit b);
    send_lvl(b);
    run = b ? run + 1 : 0;
    stuff_if_needed();
  endtask

  task automatic send_sync();
    send_sym(J); send_sym(J);
    send_sym(K); send_sym(J); send_sym(K); send_sym(J); send_sym(K); send_sym(J); send_sym(K);
    check("active_pre", {31'd0, rx_active}, 32'd0);
    send_sym(K);
    check("active_rise", {31'd0, rx_active}, 32'd1);
    lvl = K;
    run = 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      send_lvl(b[i]);
      check((i == 7) ? "valid_at_8" : "valid_early", {31'd0, rx_valid}, (i == 7) ? 32'd1 : 32'd0);
      run = b[i] ? run + 1 : 0;
      stuff_if_needed();
    end
    exp_q.push_back(32'h100 | int'(b));
    last_byte = b;
  endtask

  task automatic send_eop(input bit good);
    send_sym(SE0);
    send_sym(SE0);
    send_sym(good ? J : K);
    check("eop_pulse", {31'd0, rx_eop}, {31'd0, good});
    check("eop_active", {31'd0, rx_active}, 32'd0);
    exp_q.push_back(good ? 32'h300 : 32'h200);
  endtask

  task automatic end_scenario(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_nevt"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check({tag, "_evt"}, obs_q[i], exp_q[i]);
    check({tag, "_hold"}, {24'd0, rx_data}, {24'd0, last_byte});
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; strobe = 1'b0; q = J; lvl = J; run = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", {31'd0, rx_active}, 32'd0);
    check("rst_valid",  {31'd0, rx_valid},  32'd0);
    check("rst_error",  {31'd0, rx_error},  32'd0);
    check("rst_eop",    {31'd0, rx_eop},    32'd0);
    check("rst_data",   {24'd0, rx_data},   32'd0);
    reset = 1'b0;

    // Basic packet 0xA5
    send_sync(); send_byte(8'hA5); send_eop(1'b1);
    end_scenario("a5");

    // 0xFF needs a stuff bit after six 1s
    send_sync(); send_byte(8'hFF); send_eop(1'b1);
    end_scenario("ff");

    // Five data bits then EOP: misalignment error, no byte
    send_sync();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    exp_q.push_back(32'h200);
    send_eop(1'b1);
    end_scenario("trunc");

    // Seven 1s in a row (missing stuff transition)
    send_sync();
    for (int i = 0; i < 5; i++) send_lvl(1'b1);
    send_lvl(1'b1);
`ifdef USB_RX_STUFF_ERR_EN
    check("stuff_err", {31'd0, rx_error}, 32'd1);
    check("stuff_idle", {31'd0, rx_active}, 32'd0);
    exp_q.push_back(32'h200);
    send_sym(J); send_sym(J);
`else
    check("stuff_quiet", {31'd0, rx_error}, 32'd0);
    send_lvl(1'b1); send_lvl(1'b1); send_lvl(1'b1);
    check("stuff_byte", {31'd0, rx_valid}, 32'd1);
    exp_q.push_back(32'h1FF);
    last_byte = 8'hFF;
    send_eop(1'b1);
`endif
    end_scenario("seven");

    // Reset mid-byte (with a strobe on SE0 pending) aborts silently
    send_sync(); send_byte(8'h3C);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    reset = 1'b1; strobe = 1'b1; q = SE0;
    @(posedge clk); #1;
    reset = 1'b0; strobe = 1'b0;
    check("mid_rst_active", {31'd0, rx_active}, 32'd0);
    check("mid_rst_valid",  {31'd0, rx_valid},  32'd0);
    check("mid_rst_error",  {31'd0, rx_error},  32'd0);
    check("mid_rst_eop",    {31'd0, rx_eop},    32'd0);
    check("mid_rst_data",   {24'd0, rx_data},   32'd0);
    last_byte = 8'h00;
    end_scenario("rst");
    send_sync(); send_byte(8'h81); send_eop(1'b1);
    end_scenario("post_rst");

    // K during EOP: error, no eop
    send_sync(); send_byte(8'($urandom_range(0, 255))); send_eop(1'b0);
    end_scenario("eop_k");

    // Random packets
    for (int p = 0; p < 24; p++) begin
      int nbytes, ntrunc;
      logic [7:0] b;
      nbytes = $urandom_range(0, 3);
      ntrunc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      send_sync();
      for (int i = 0; i < nbytes; i++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        send_byte(b);
      end
      for (int i = 0; i < ntrunc; i++) send_bit(1'($urandom_range(0, 1)));
      if (ntrunc != 0) exp_q.push_back(32'h200);
      send_eop(1'($urandom_range(0, 3) != 0));
      end_scenario("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
